// File: rtl/rob_completion_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_completion_tracker_pkg
// Description : Shared ROB sizing constants and ID type used by rename,
//               the writeback stages, retire and the completion tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_completion_tracker_pkg;

  localparam int ROB_ENTRIES = 32;
  localparam int ROB_ID_W    = 5;

  typedef logic [ROB_ID_W-1:0] rob_id_t;

endpackage
`default_nettype wire

// File: rtl/rob_completion_tracker.sv
`default_nettype none
// ============================================================================
// Module      : rob_completion_tracker
// Description : Reorder-buffer valid/done tracker. Allocates up to two slots
//               in order at the tail, marks slots done from two writeback
//               ports and retires up to two done slots per cycle from the head.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_completion_tracker
  import rob_completion_tracker_pkg::*;
#(
  parameter int ENTRIES = ROB_ENTRIES,
  parameter int ID_W    = ROB_ID_W
) (
  input  logic            cpu_clock_i,
  input  logic            cpu_reset_i,
  input  logic            flush_i,
  input  logic [1:0]      alloc_req_i,
  output logic            alloc_ready_o,
  output logic [ID_W-1:0] alloc_id0_o,
  output logic [ID_W-1:0] alloc_id1_o,
  input  logic [ID_W-1:0] p0_rob_id_i,
  input  logic            p0_rob_valid_i,
  input  logic [ID_W-1:0] p1_rob_id_i,
  input  logic            p1_rob_valid_i,
  output logic [1:0]      commit_valid_o,
  output logic [ID_W-1:0] commit_id0_o,
  output logic [ID_W-1:0] commit_id1_o,
  output logic            empty_o,
  output logic            full_o
);

  // Two free slots are needed to accept a request, so the last count
  // that still admits allocation is ENTRIES-2.
  localparam logic [ID_W:0] c_ready_max = (ID_W+1)'(ENTRIES - 2);
  localparam logic [ID_W:0] c_full_cnt  = (ID_W+1)'(ENTRIES);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] done_q,  done_d;
  logic [ID_W-1:0]    head_q,  head_d;
  logic [ID_W-1:0]    tail_q,  tail_d;
  logic [ID_W:0]      count_q, count_d;

  logic [ID_W-1:0]    w_head_p1;
  logic [ID_W-1:0]    w_tail_p1;
  logic               w_commit0;
  logic               w_commit1;
  logic               w_alloc_ready;
  logic [1:0]         w_n_alloc;
  logic [1:0]         w_n_commit;

  // Head/tail neighbours, commit eligibility and allocation acceptance,
  // all derived from registered state only.
  always_comb begin
    w_head_p1     = head_q + ID_W'(1);
    w_tail_p1     = tail_q + ID_W'(1);
    w_commit0     = valid_q[head_q] & done_q[head_q];
    w_commit1     = w_commit0 & valid_q[w_head_p1] & done_q[w_head_p1];
    w_alloc_ready = (count_q <= c_ready_max);
    w_n_alloc     = w_alloc_ready ? ({1'b0, alloc_req_i[0]} + {1'b0, alloc_req_i[1]}) : 2'd0;
    w_n_commit    = {1'b0, w_commit0} + {1'b0, w_commit1};
  end

  // Next-state: flush empties everything; otherwise per-slot set/clear for
  // completion, commit and allocation, applied in that order so a freshly
  // allocated slot always starts with done=0.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (p0_rob_valid_i && (p0_rob_id_i == ID_W'(i)) && valid_q[i]) begin
          done_d[i] = 1'b1;
        end
        if (p1_rob_valid_i && (p1_rob_id_i == ID_W'(i)) && valid_q[i]) begin
          done_d[i] = 1'b1;
        end
        if ((w_commit0 && (head_q == ID_W'(i))) ||
            (w_commit1 && (w_head_p1 == ID_W'(i)))) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end
        if (((w_n_alloc != 2'd0) && (tail_q == ID_W'(i))) ||
            ((w_n_alloc == 2'd2) && (w_tail_p1 == ID_W'(i)))) begin
          valid_d[i] = 1'b1;
          done_d[i]  = 1'b0;
        end
      end
      head_d  = head_q + ID_W'(w_n_commit);
      tail_d  = tail_q + ID_W'(w_n_alloc);
      count_d = count_q + (ID_W+1)'(w_n_alloc) - (ID_W+1)'(w_n_commit);
    end
  end

  // State registers with synchronous reset to the empty tracker.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Outputs are combinational from state; commit is suppressed during flush.
  always_comb begin
    alloc_ready_o  = w_alloc_ready;
    alloc_id0_o    = tail_q;
    alloc_id1_o    = w_tail_p1;
    commit_valid_o = flush_i ? 2'b00 : {w_commit1, w_commit0};
    commit_id0_o   = head_q;
    commit_id1_o   = w_head_p1;
    empty_o        = (count_q == '0);
    full_o         = (count_q == c_full_cnt);
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_completion_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_completion_tracker
// Description : Self-checking bench for rob_completion_tracker. A queue of
//               in-flight ROB IDs plus a done table serves as reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_completion_tracker;
  import rob_completion_tracker_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic [1:0]    alloc_req_i;
  logic          alloc_ready_o;
  rob_id_t       alloc_id0_o, alloc_id1_o;
  rob_id_t       p0_rob_id_i, p1_rob_id_i;
  logic          p0_rob_valid_i, p1_rob_valid_i;
  logic [1:0]    commit_valid_o;
  rob_id_t       commit_id0_o, commit_id1_o;
  logic          empty_o, full_o;

  always #5 clk = ~clk;

  rob_completion_tracker dut (
    .cpu_clock_i    (clk),
    .cpu_reset_i    (rst),
    .flush_i        (flush_i),
    .alloc_req_i    (alloc_req_i),
    .alloc_ready_o  (alloc_ready_o),
    .alloc_id0_o    (alloc_id0_o),
    .alloc_id1_o    (alloc_id1_o),
    .p0_rob_id_i    (p0_rob_id_i),
    .p0_rob_valid_i (p0_rob_valid_i),
    .p1_rob_id_i    (p1_rob_id_i),
    .p1_rob_valid_i (p1_rob_valid_i),
    .commit_valid_o (commit_valid_o),
    .commit_id0_o   (commit_id0_o),
    .commit_id1_o   (commit_id1_o),
    .empty_o        (empty_o),
    .full_o         (full_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: in-order list of allocated IDs, done flags, next tail.
  int rob_q[$];
  bit done_m[32];
  int tail_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit in_rob(input int id);
    foreach (rob_q[k]) if (rob_q[k] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_head();
    return (tail_m - rob_q.size() + 64) % 32;
  endfunction

  function automatic bit lane0_ok();
    return (rob_q.size() >= 1) && done_m[rob_q[0]];
  endfunction

  function automatic bit lane1_ok();
    return lane0_ok() && (rob_q.size() >= 2) && done_m[rob_q[1]];
  endfunction

  task automatic model_clear();
    rob_q.delete();
    foreach (done_m[k]) done_m[k] = 1'b0;
    tail_m = 0;
  endtask

  task automatic check_outputs();
    int  cnt;
    int  hd;
    logic [1:0] cv;
    cnt = rob_q.size();
    hd  = model_head();
    cv  = flush_i ? 2'b00 : {lane1_ok(), lane0_ok()};
    check("alloc_ready", alloc_ready_o, cnt <= 30);
    check("alloc_id0", alloc_id0_o, tail_m);
    check("alloc_id1", alloc_id1_o, (tail_m + 1) % 32);
    check("commit_valid", commit_valid_o, cv);
    check("commit_id0", commit_id0_o, hd);
    check("commit_id1", commit_id1_o, (hd + 1) % 32);
    check("empty", empty_o, cnt == 0);
    check("full", full_o, cnt == 32);
  endtask

  task automatic model_update();
    bit ready;
    int ncommit;
    int nalloc;
    if (rst || flush_i) begin
      model_clear();
      return;
    end
    ready   = rob_q.size() <= 30;
    ncommit = lane1_ok() ? 2 : (lane0_ok() ? 1 : 0);
    if (p0_rob_valid_i && in_rob(int'(p0_rob_id_i))) done_m[p0_rob_id_i] = 1'b1;
    if (p1_rob_valid_i && in_rob(int'(p1_rob_id_i))) done_m[p1_rob_id_i] = 1'b1;
    repeat (ncommit) begin
      done_m[rob_q[0]] = 1'b0;
      void'(rob_q.pop_front());
    end
    nalloc = ready ? (int'(alloc_req_i[0]) + int'(alloc_req_i[1])) : 0;
    repeat (nalloc) begin
      rob_q.push_back(tail_m);
      done_m[tail_m] = 1'b0;
      tail_m = (tail_m + 1) % 32;
    end
  endtask

  // One clock: drive at the falling edge, check mid-low-phase, then update
  // the model for the coming rising edge. Returns with inputs still applied.
  task automatic cycle(input logic [1:0] req, input logic v0, input logic [4:0] id0,
                       input logic v1, input logic [4:0] id1, input logic fl, input logic rs);
    @(negedge clk);
    alloc_req_i    = req;
    p0_rob_valid_i = v0;
    p0_rob_id_i    = id0;
    p1_rob_valid_i = v1;
    p1_rob_id_i    = id1;
    flush_i        = fl;
    rst            = rs;
    #1;
    check_outputs();
    model_update();
  endtask

  task automatic idle();
    cycle(2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [4:0] pick_id();
    if (rob_q.size() != 0 && $urandom_range(0, 3) != 0)
      return 5'(rob_q[$urandom_range(0, rob_q.size() - 1)]);
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [1:0] rq;
    rst = 1'b1; flush_i = 1'b0; alloc_req_i = 2'b00;
    p0_rob_valid_i = 1'b0; p0_rob_id_i = '0;
    p1_rob_valid_i = 1'b0; p1_rob_id_i = '0;
    model_clear();
    @(posedge clk);

    // Reset state
    idle();
    check("rst_ready", alloc_ready_o, 1);
    check("rst_id1", alloc_id1_o, 1);
    check("rst_empty", empty_o, 1);

    // Three paired allocations: IDs 0..5
    repeat (3) cycle(2'b11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    check("after3_tail", alloc_id0_o, 6);
    check("after3_empty", empty_o, 0);

    // Both ports on ID 4, then a strobe to unallocated ID 20
    cycle(2'b00, 1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 1'b0);
    cycle(2'b00, 1'b1, 5'd20, 1'b0, 5'd0, 1'b0, 1'b0);

    // Out-of-order completion: 1 then 0
    cycle(2'b00, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(2'b00, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("no_commit_after_1", commit_valid_o, 2'b00);
    idle();
    check("commit_pair", commit_valid_o, 2'b11);
    check("commit_pair_id1", commit_id1_o, 1);

    // Fill to full, then dropped requests leave tail unchanged
    for (int k = 0; k < 20 && rob_q.size() < 32; k++)
      cycle(2'b11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("full_flag", full_o, 1);
    check("full_not_ready", alloc_ready_o, 0);
    check("full_tail", alloc_id0_o, 2);
    cycle(2'b11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("drop_tail", alloc_id0_o, 2);

    // Drain head up to 31
    for (int i = 2; i <= 28; i += 2)
      cycle(2'b00, 1'b1, 5'(i), 1'b1, 5'(i + 1), 1'b0, 1'b0);
    cycle(2'b00, 1'b1, 5'd30, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (4) idle();
    check("head31", commit_id0_o, 31);

    // Wrap commit (31,0)
    cycle(2'b00, 1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 1'b0);
    idle();
    check("wrap_commit", commit_valid_o, 2'b11);
    check("wrap_id0", commit_id0_o, 31);
    check("wrap_id1", commit_id1_o, 0);
    idle();
    check("wrap_head", commit_id0_o, 1);

    // Flush with pending commit, allocation and completions
    cycle(2'b00, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(2'b11, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b0);
    check("flush_gate", commit_valid_o, 2'b00);
    idle();
    check("flush_empty", empty_o, 1);
    check("flush_tail", alloc_id0_o, 0);
    cycle(2'b11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(2'b00, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    check("no_stale_done", commit_valid_o, 2'b01);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 2))
        0:       rq = 2'b00;
        1:       rq = 2'b01;
        default: rq = 2'b11;
      endcase
      cycle(rq, 1'($urandom_range(0, 1)), pick_id(), 1'($urandom_range(0, 1)), pick_id(),
            ($urandom_range(0, 59) == 0), ($urandom_range(0, 249) == 0));
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
